// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, LSB first through one full-subtractor cell with registered borrow.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res, res_nxt;
  logic [CW-1:0] count;
  logic borrow, x, y, d, bout, last;
  always_comb begin
    x = sa[0];
    y = sb[0];
    d = x ^ y ^ borrow;
    bout = (~x & y) | (~(x ^ y) & borrow);
    res_nxt = {d, res[WIDTH-1:1]};
    last = count == CW'(WIDTH - 1);
    state_nxt = state == IDLE ? (start ? SHIFT : IDLE) :
                state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      res <= '0;
      borrow <= 1'b0;
      count <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        sa <= a;
        sb <= b;
        borrow <= 1'b0;
        count <= '0;
      end else if (state == SHIFT) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        res <= res_nxt;
        borrow <= bout;
        count <= count + 1'b1;
        if (last) begin
          diff <= res_nxt;
          borrow_out <= bout;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: table-driven vectors plus hand-written corner sequences for serial_sub.
module tb_serial_sub;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic busy, done, borrow_out;
  int nvec = 0, nerr = 0;

  serial_sub #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation and watches 14 cycles; optionally re-pulses start at a given cycle.
  task automatic run(input logic [7:0] va, input logic [7:0] vb, input int pulse_at,
                     output int done_at, output int ndone, output int busy_hi);
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    done_at = -1; ndone = 0; busy_hi = busy ? 1 : 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == pulse_at + 1 && pulse_at > 0) begin a = 8'hFF; b = 8'h00; start = 1'b1; end
      tick();
      start = 1'b0;
      if (busy) busy_hi++;
      if (done) begin ndone++; if (done_at < 0) done_at = k; end
    end
  endtask

  initial begin
    int da, nd, bh, k;
    logic [7:0] pa, pb;
    tbl[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    tbl[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    tbl[6] = '{8'h01, 8'h02, 8'hFF, 1'b1};
    tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    tbl[8] = '{8'hC3, 8'h3C, 8'h87, 1'b0};

    #2 reset = 1'b1;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset borrow", borrow_out, 0);
    #1 reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run(tbl[i].a, tbl[i].b, 0, da, nd, bh);
      chk($sformatf("vec%0d done cycle", i), da, 8);
      chk($sformatf("vec%0d done count", i), nd, 1);
      chk($sformatf("vec%0d busy cycles", i), bh, 9);
      chk($sformatf("vec%0d diff", i), diff, tbl[i].d);
      chk($sformatf("vec%0d borrow", i), borrow_out, tbl[i].bo);
    end

    run(8'h5A, 8'h23, 3, da, nd, bh);
    chk("ignore done cycle", da, 8);
    chk("ignore done count", nd, 1);
    chk("ignore busy cycles", bh, 9);
    chk("ignore diff", diff, 8'h37);
    chk("ignore borrow", borrow_out, 0);

    a = 8'h5A; b = 8'h23; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort borrow", borrow_out, 0);
    #1 reset = 1'b0;
    nd = 0;
    for (int j = 0; j < 12; j++) begin tick(); if (done) nd++; end
    chk("abort no done", nd, 0);
    run(8'h10, 8'h01, 0, da, nd, bh);
    chk("after abort done cycle", da, 8);
    chk("after abort diff", diff, 8'h0F);
    chk("after abort borrow", borrow_out, 0);

    // Held start: accepts every 10 cycles, new operands applied right after each done.
    pa = 8'h00; pb = 8'h00;
    a = pa; b = pb; start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      k = 0;
      do begin tick(); k++; end while (!done && k < 12);
      chk($sformatf("b2b%0d interval", i), k, i == 0 ? 9 : 10);
      chk($sformatf("b2b%0d diff", i), diff, 8'(pa - pb));
      chk($sformatf("b2b%0d borrow", i), borrow_out, pa < pb ? 1 : 0);
      pa = 8'((i + 1) * 53 + 17);
      pb = 8'((i + 1) * 29 + 7);
      a = pa; b = pb;
      if (i == 255) start = 1'b0;
    end
    tick();
    chk("b2b final done low", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
